// File: rtl/writeback_unit.sv
// Register-file writeback arbiter: merges ALU results and formatted load responses
// onto one registered write port, with a one-entry hold buffer for ALU results.
module writeback_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_result,
  output logic        alu_ready,
  input  logic        load_issue,
  input  logic [4:0]  load_rd,
  input  logic [2:0]  load_funct3,
  input  logic [1:0]  load_addr_low,
  output logic        load_ready,
  input  logic        mem_read_valid,
  input  logic [31:0] mem_read_data,
  output logic [4:0]  register_write,
  output logic [31:0] write_data,
  output logic        register_write_enable,
  output logic        load_pending,
  output logic        load_error
);

  typedef enum logic [0:0] {StIdle, StLoadWait} state_e;

  state_e      state_q, state_d;
  logic [4:0]  ld_rd_q;
  logic [2:0]  ld_funct3_q;
  logic [1:0]  ld_off_q;
  logic        hold_full_q, hold_full_d;
  logic [4:0]  hold_rd_q, hold_rd_d;
  logic [31:0] hold_data_q, hold_data_d;
  logic [4:0]  reg_write_q, reg_write_d;
  logic [31:0] write_data_q, write_data_d;
  logic        wr_en_q, wr_en_d;
  logic        load_error_q, load_error_d;

  logic        load_acc, alu_acc, load_resp, ld_err;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  assign load_acc  = load_issue && (state_q == StIdle);
  assign alu_acc   = alu_valid && !hold_full_q;
  assign load_resp = mem_read_valid && (state_q == StLoadWait);
  assign alu_ready = !hold_full_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:     if (load_issue) state_d = StLoadWait;
      StLoadWait: if (mem_read_valid) state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  always_comb begin
    load_ready   = (state_q == StIdle);
    load_pending = (state_q == StLoadWait);
  end

  always_comb begin
    case (ld_off_q)
      2'd0:    ld_byte = mem_read_data[7:0];
      2'd1:    ld_byte = mem_read_data[15:8];
      2'd2:    ld_byte = mem_read_data[23:16];
      default: ld_byte = mem_read_data[31:24];
    endcase
    ld_half = ld_off_q[1] ? mem_read_data[31:16] : mem_read_data[15:0];
    ld_err  = 1'b0;
    ld_data = mem_read_data;
    case (ld_funct3_q)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_data = {24'h0, ld_byte};
      3'b001: begin
        ld_data = {{16{ld_half[15]}}, ld_half};
        ld_err  = ld_off_q[0];
      end
      3'b101: begin
        ld_data = {16'h0, ld_half};
        ld_err  = ld_off_q[0];
      end
      3'b010:  ld_err = (ld_off_q != 2'd0);
      default: ld_err = 1'b1;
    endcase
  end

  // Priority: load response > hold buffer > new ALU result.
  always_comb begin
    hold_full_d  = hold_full_q;
    hold_rd_d    = hold_rd_q;
    hold_data_d  = hold_data_q;
    reg_write_d  = reg_write_q;
    write_data_d = write_data_q;
    wr_en_d      = 1'b0;
    load_error_d = 1'b0;
    if (load_resp) begin
      load_error_d = ld_err;
      if (!ld_err) begin
        reg_write_d  = ld_rd_q;
        write_data_d = ld_data;
        wr_en_d      = (ld_rd_q != 5'd0);
      end
      if (alu_acc) begin
        hold_full_d = 1'b1;
        hold_rd_d   = alu_rd;
        hold_data_d = alu_result;
      end
    end else if (hold_full_q) begin
      reg_write_d  = hold_rd_q;
      write_data_d = hold_data_q;
      wr_en_d      = (hold_rd_q != 5'd0);
      hold_full_d  = 1'b0;
    end else if (alu_acc) begin
      reg_write_d  = alu_rd;
      write_data_d = alu_result;
      wr_en_d      = (alu_rd != 5'd0);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ld_rd_q      <= 5'd0;
      ld_funct3_q  <= 3'd0;
      ld_off_q     <= 2'd0;
      hold_full_q  <= 1'b0;
      hold_rd_q    <= 5'd0;
      hold_data_q  <= 32'd0;
      reg_write_q  <= 5'd0;
      write_data_q <= 32'd0;
      wr_en_q      <= 1'b0;
      load_error_q <= 1'b0;
    end else begin
      if (load_acc) begin
        ld_rd_q     <= load_rd;
        ld_funct3_q <= load_funct3;
        ld_off_q    <= load_addr_low;
      end
      hold_full_q  <= hold_full_d;
      hold_rd_q    <= hold_rd_d;
      hold_data_q  <= hold_data_d;
      reg_write_q  <= reg_write_d;
      write_data_q <= write_data_d;
      wr_en_q      <= wr_en_d;
      load_error_q <= load_error_d;
    end
  end

  assign register_write        = reg_write_q;
  assign write_data            = write_data_q;
  assign register_write_enable = wr_en_q;
  assign load_error            = load_error_q;

endmodule

// File: tb/tb_writeback_unit.sv
// Directed bench for writeback_unit: table of load formatting vectors plus
// hand sequences for ALU writes, collisions, x0 writes and reset mid-load.
module tb_writeback_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        alu_valid = 1'b0;
  logic [4:0]  alu_rd = 5'd0;
  logic [31:0] alu_result = 32'd0;
  logic        alu_ready;
  logic        load_issue = 1'b0;
  logic [4:0]  load_rd = 5'd0;
  logic [2:0]  load_funct3 = 3'd0;
  logic [1:0]  load_addr_low = 2'd0;
  logic        load_ready;
  logic        mem_read_valid = 1'b0;
  logic [31:0] mem_read_data = 32'd0;
  logic [4:0]  register_write;
  logic [31:0] write_data;
  logic        register_write_enable;
  logic        load_pending;
  logic        load_error;

  int n_cmp = 0;
  int n_fail = 0;

  writeback_unit dut (
    .clk                   (clk),
    .reset                 (reset),
    .alu_valid             (alu_valid),
    .alu_rd                (alu_rd),
    .alu_result            (alu_result),
    .alu_ready             (alu_ready),
    .load_issue            (load_issue),
    .load_rd               (load_rd),
    .load_funct3           (load_funct3),
    .load_addr_low         (load_addr_low),
    .load_ready            (load_ready),
    .mem_read_valid        (mem_read_valid),
    .mem_read_data         (mem_read_data),
    .register_write        (register_write),
    .write_data            (write_data),
    .register_write_enable (register_write_enable),
    .load_pending          (load_pending),
    .load_error            (load_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  f3;
    logic [1:0]  off;
    logic [4:0]  rd;
    logic [31:0] mem;
    logic [31:0] exp_data;
    logic        exp_err;
  } ld_vec_t;

  ld_vec_t vecs[11];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  initial begin
    vecs[0]  = '{3'b000, 2'd2, 5'd7,  32'h0080_0000, 32'hFFFF_FF80, 1'b0};
    vecs[1]  = '{3'b100, 2'd1, 5'd8,  32'h0000_AB00, 32'h0000_00AB, 1'b0};
    vecs[2]  = '{3'b000, 2'd3, 5'd9,  32'h7F00_0000, 32'h0000_007F, 1'b0};
    vecs[3]  = '{3'b001, 2'd2, 5'd10, 32'h8001_0000, 32'hFFFF_8001, 1'b0};
    vecs[4]  = '{3'b101, 2'd0, 5'd11, 32'h1234_F00D, 32'h0000_F00D, 1'b0};
    vecs[5]  = '{3'b010, 2'd0, 5'd12, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0};
    vecs[6]  = '{3'b010, 2'd1, 5'd13, 32'h1111_1111, 32'h0,         1'b1};
    vecs[7]  = '{3'b001, 2'd1, 5'd14, 32'h2222_2222, 32'h0,         1'b1};
    vecs[8]  = '{3'b011, 2'd0, 5'd15, 32'h3333_3333, 32'h0,         1'b1};
    vecs[9]  = '{3'b000, 2'd0, 5'd0,  32'h0000_0055, 32'h0000_0055, 1'b0};
    vecs[10] = '{3'b110, 2'd0, 5'd16, 32'h4444_4444, 32'h0,         1'b1};

    // Reset state
    tick();
    tick();
    chk("rst_we", register_write_enable, 0);
    chk("rst_err", load_error, 0);
    chk("rst_rw", register_write, 0);
    chk("rst_wd", write_data, 0);
    reset = 1'b0;
    chk("rst_alu_ready", alu_ready, 1);
    chk("rst_load_ready", load_ready, 1);
    chk("rst_pending", load_pending, 0);

    // Plain ALU write
    alu_valid = 1'b1; alu_rd = 5'd5; alu_result = 32'h0000_1234;
    tick();
    alu_valid = 1'b0;
    chk("alu_we", register_write_enable, 1);
    chk("alu_rw", register_write, 5);
    chk("alu_wd", write_data, 32'h0000_1234);
    tick();
    chk("idle_we", register_write_enable, 0);
    chk("idle_rw_held", register_write, 5);
    chk("idle_wd_held", write_data, 32'h0000_1234);

    // ALU write to x0
    alu_valid = 1'b1; alu_rd = 5'd0; alu_result = 32'h0000_0099;
    tick();
    alu_valid = 1'b0;
    chk("x0_we", register_write_enable, 0);
    chk("x0_alu_ready", alu_ready, 1);

    // Load formatting / error table
    for (int i = 0; i < 11; i++) begin
      load_issue = 1'b1; load_rd = vecs[i].rd;
      load_funct3 = vecs[i].f3; load_addr_low = vecs[i].off;
      tick();
      load_issue = 1'b0;
      chk($sformatf("ld%0d_pending", i), load_pending, 1);
      chk($sformatf("ld%0d_ready", i), load_ready, 0);
      mem_read_valid = 1'b1; mem_read_data = vecs[i].mem;
      tick();
      mem_read_valid = 1'b0;
      chk($sformatf("ld%0d_we", i), register_write_enable,
          (!vecs[i].exp_err && vecs[i].rd != 5'd0) ? 1 : 0);
      chk($sformatf("ld%0d_err", i), load_error, vecs[i].exp_err);
      chk($sformatf("ld%0d_pending_low", i), load_pending, 0);
      chk($sformatf("ld%0d_idle", i), load_ready, 1);
      if (!vecs[i].exp_err && vecs[i].rd != 5'd0) begin
        chk($sformatf("ld%0d_rw", i), register_write, vecs[i].rd);
        chk($sformatf("ld%0d_wd", i), write_data, vecs[i].exp_data);
      end
      tick();
      chk($sformatf("ld%0d_err_pulse", i), load_error, 0);
    end

    // Collision: load response beats ALU; ALU held and written next
    load_issue = 1'b1; load_rd = 5'd3; load_funct3 = 3'b101; load_addr_low = 2'd2;
    tick();
    load_issue = 1'b0;
    mem_read_valid = 1'b1; mem_read_data = 32'hBEEF_0000;
    alu_valid = 1'b1; alu_rd = 5'd4; alu_result = 32'h0000_0011;
    tick();
    mem_read_valid = 1'b0;
    alu_rd = 5'd20; alu_result = 32'h0000_0077;  // must be ignored while full
    chk("col_n1_we", register_write_enable, 1);
    chk("col_n1_rw", register_write, 3);
    chk("col_n1_wd", write_data, 32'h0000_BEEF);
    chk("col_n1_alu_ready", alu_ready, 0);
    tick();
    alu_valid = 1'b0;
    chk("col_n2_we", register_write_enable, 1);
    chk("col_n2_rw", register_write, 4);
    chk("col_n2_wd", write_data, 32'h0000_0011);
    chk("col_n2_alu_ready", alu_ready, 1);
    tick();
    chk("col_n3_we", register_write_enable, 0);
    chk("col_n3_rw", register_write, 4);

    // Simultaneous load issue and ALU in IDLE
    load_issue = 1'b1; load_rd = 5'd21; load_funct3 = 3'b010; load_addr_low = 2'd0;
    alu_valid = 1'b1; alu_rd = 5'd22; alu_result = 32'hCAFE_0001;
    tick();
    load_issue = 1'b0; alu_valid = 1'b0;
    chk("sim_we", register_write_enable, 1);
    chk("sim_rw", register_write, 22);
    chk("sim_pending", load_pending, 1);
    mem_read_valid = 1'b1; mem_read_data = 32'h0BAD_F00D;
    tick();
    mem_read_valid = 1'b0;
    chk("sim_ld_rw", register_write, 21);
    chk("sim_ld_wd", write_data, 32'h0BAD_F00D);

    // Reset in LOAD_WAIT abandons the load
    load_issue = 1'b1; load_rd = 5'd6; load_funct3 = 3'b010; load_addr_low = 2'd0;
    tick();
    load_issue = 1'b0;
    chk("rml_pending", load_pending, 1);
    reset = 1'b1; mem_read_valid = 1'b1; mem_read_data = 32'h5555_AAAA;
    tick();
    reset = 1'b0;
    chk("rml_pending_low", load_pending, 0);
    chk("rml_load_ready", load_ready, 1);
    chk("rml_we_rst", register_write_enable, 0);
    tick();
    mem_read_valid = 1'b0;
    chk("rml_we", register_write_enable, 0);
    chk("rml_err", load_error, 0);
    chk("rml_pending_after", load_pending, 0);
    chk("rml_wd", write_data, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
